icestick_led_top: RTL and testbench

Top-level LED pattern generator for the iCEstick board. A parameterisable prescaler divides the board clock into a step tick. On each tick, a 3-bit pattern sequencer advances and drives the three board LEDs: LED5, LED4 and LED3. It is the root of the FPGA design and has no other outputs.

---
 rtl/icestick_pkg.sv | 28 ++
 rtl/icestick_led_top_tick_gen.sv | 28 ++
 rtl/icestick_led_top.sv | 47 ++++
 tb/tb_icestick_led_top.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/icestick_pkg.sv
// Shared pattern definitions for the iCEstick LED sequencer: mode codes,
// sequence lengths and the step-to-LED decode.
package icestick_pkg;

  localparam int MODE_BINARY = 0;
  localparam int MODE_CHASE  = 1;
  localparam int MODE_GRAY   = 2;
  localparam int MODE_TOGGLE = 3;

  // Number of distinct steps before the sequence repeats; unknown modes act as binary.
  function automatic int step_mod(input int mode);
    case (mode)
      MODE_CHASE:  return 3;
      MODE_TOGGLE: return 2;
      default:     return 8;
    endcase
  endfunction

  function automatic logic [2:0] led_decode(input int mode, input logic [2:0] step);
    case (mode)
      MODE_CHASE:  return 3'b001 << step;
      MODE_GRAY:   return step ^ (step >> 1);
      MODE_TOGGLE: return {3{step[0]}};
      default:     return step;
    endcase
  endfunction

endpackage

// File: rtl/icestick_led_top_tick_gen.sv
// Prescaler: counts 0..PRESCALE-1 and flags the last count as the step tick.
module tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

  // Power-up value matches reset so the board runs with rst tied low.
  logic [CW-1:0] r_cnt = '0;

  assign tick = (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/icestick_led_top.sv
// iCEstick root: prescaled step counter driving LED5..LED3 straight from flops.
module icestick_led_top #(
  parameter int PRESCALE = 4,
  parameter int MODE     = 0
) (
  input  logic clk,
  input  logic rst,
  output logic LED5,
  output logic LED4,
  output logic LED3
);
  import icestick_pkg::*;

  localparam logic [2:0] STEP_LAST = 3'(step_mod(MODE) - 1);
  localparam logic [2:0] LED_RESET = led_decode(MODE, 3'd0);

  logic       w_tick;
  logic [2:0] w_step_next;
  logic [2:0] r_step = 3'd0;
  logic [2:0] r_led  = LED_RESET;

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(w_tick)
  );

  always_comb begin
    w_step_next = (r_step == STEP_LAST) ? 3'd0 : r_step + 3'd1;
  end

  // LEDs load the decode of the next step so they change on the tick edge itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step <= 3'd0;
      r_led  <= LED_RESET;
    end else if (w_tick) begin
      r_step <= w_step_next;
      r_led  <= led_decode(MODE, w_step_next);
    end
  end

  assign {LED5, LED4, LED3} = r_led;

endmodule

// File: tb/tb_icestick_led_top.sv
// Bench: six parameterisations against a step-index model, plus literal pins.
module tb_icestick_led_top;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wire [2:0] led0, led1, led2, led3, led4, led5;
  logic [2:0] leds [6];

  icestick_led_top #(.PRESCALE(4), .MODE(0)) u_m0 (.clk(clk), .rst(rst),  .LED5(led0[2]), .LED4(led0[1]), .LED3(led0[0]));
  icestick_led_top #(.PRESCALE(4), .MODE(1)) u_m1 (.clk(clk), .rst(rst),  .LED5(led1[2]), .LED4(led1[1]), .LED3(led1[0]));
  icestick_led_top #(.PRESCALE(2), .MODE(2)) u_m2 (.clk(clk), .rst(rst),  .LED5(led2[2]), .LED4(led2[1]), .LED3(led2[0]));
  icestick_led_top #(.PRESCALE(1), .MODE(3)) u_m3 (.clk(clk), .rst(rst),  .LED5(led3[2]), .LED4(led3[1]), .LED3(led3[0]));
  icestick_led_top #(.PRESCALE(3), .MODE(6)) u_m6 (.clk(clk), .rst(rst),  .LED5(led4[2]), .LED4(led4[1]), .LED3(led4[0]));
  icestick_led_top #(.PRESCALE(4), .MODE(0)) u_nr (.clk(clk), .rst(1'b0), .LED5(led5[2]), .LED4(led5[1]), .LED3(led5[0]));

  always_comb begin
    leds[0] = led0;
    leds[1] = led1;
    leds[2] = led2;
    leds[3] = led3;
    leds[4] = led4;
    leds[5] = led5;
  end

  int modes [6] = '{0, 1, 2, 3, 6, 0};
  int pres  [6] = '{4, 4, 2, 1, 3, 4};
  int since [6] = '{0, 0, 0, 0, 0, 0};
  logic [2:0] gray_tab [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Expected pattern from the number of unreset edges seen: step index = edges / PRESCALE.
  function automatic logic [2:0] model_led(input int mode, input int p, input int n);
    int idx;
    case (mode)
      1: begin
        idx = (n / p) % 3;
        return (idx == 0) ? 3'b001 : (idx == 1) ? 3'b010 : 3'b100;
      end
      2: begin
        idx = (n / p) % 8;
        return gray_tab[idx];
      end
      3: begin
        idx = (n / p) % 2;
        return (idx == 1) ? 3'b111 : 3'b000;
      end
      default: begin
        idx = (n / p) % 8;
        return 3'(idx);
      end
    endcase
  endfunction

  // Per-edge compare of every instance against the model.
  initial begin : compare
    logic       r;
    logic [2:0] prev_gray;
    #1;
    for (int i = 0; i < 6; i++) chk($sformatf("powerup[%0d]", i), leds[i], model_led(modes[i], pres[i], 0));
    prev_gray = leds[2];
    forever begin
      @(posedge clk);
      r = rst;
      #1;
      for (int i = 0; i < 6; i++) begin
        if (i != 5 && r) since[i] = 0;
        else since[i] = since[i] + 1;
        chk($sformatf("model[%0d]", i), leds[i], model_led(modes[i], pres[i], since[i]));
      end
      chk_int("chase_onehot", $countones(leds[1]), 1);
      if (!r && leds[2] !== prev_gray) chk_int("gray_onebit", $countones(leds[2] ^ prev_gray), 1);
      prev_gray = leds[2];
    end
  end

  task automatic step_edge(input logic r);
    @(negedge clk);
    rst = r;
    @(posedge clk);
    #2;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
    $fatal(1, "bench timeout");
  end

  initial begin : main
    logic [2:0] gray_exp [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    logic [2:0] prev;
    int changes;

    // Reset for two edges (t=5 and t=15), then release.
    step_edge(1'b1);
    prev = leds[0];
    changes = 0;
    for (int k = 1; k <= 50; k++) begin
      step_edge(1'b0);
      if (leds[0] !== prev) changes++;
      prev = leds[0];
      if (k == 3)  chk("m0_k3",  leds[0], 3'b000);
      if (k == 4)  chk("m0_k4",  leds[0], 3'b001);
      if (k == 8)  chk("m0_k8",  leds[0], 3'b010);
      if (k == 28) chk("m0_k28", leds[0], 3'b111);
      if (k == 32) chk("m0_k32", leds[0], 3'b000);
      if (k == 4)  chk("m1_k4",  leds[1], 3'b010);
      if (k == 8)  chk("m1_k8",  leds[1], 3'b100);
      if (k == 12) chk("m1_k12", leds[1], 3'b001);
      if (k <= 16 && k % 2 == 0) chk($sformatf("m2_k%0d", k), leds[2], gray_exp[k/2 - 1]);
      if (k == 1)  chk("m3_k1",  leds[3], 3'b111);
      if (k == 2)  chk("m3_k2",  leds[3], 3'b000);
      if (k == 1)  chk("nr_e3",  leds[5], 3'b000);
      if (k == 2)  chk("nr_e4",  leds[5], 3'b001);
      $display("phaseA k=%0d leds=%b %b %b %b %b %b", k, leds[0], leds[1], leds[2], leds[3], leds[4], leds[5]);
    end
    chk_int("m0_updates_50", changes, 12);

    // Reset pulse mid-run at edge 10 (L=010, cnt=1).
    step_edge(1'b1);
    for (int k = 1; k <= 20; k++) begin
      step_edge(k == 10);
      if (k == 9)  chk("mid_k9",  leds[0], 3'b010);
      if (k == 10) chk("mid_k10", leds[0], 3'b000);
      if (k == 13) chk("mid_k13", leds[0], 3'b000);
      if (k == 14) chk("mid_k14", leds[0], 3'b001);
      $display("phaseB k=%0d rst=%0d led0=%b", k, (k == 10), leds[0]);
    end

    // Reset coincident with the second tick.
    step_edge(1'b1);
    for (int k = 1; k <= 12; k++) begin
      step_edge(k == 8);
      if (k == 7)  chk("tick_k7",  leds[0], 3'b001);
      if (k == 8)  chk("tick_k8",  leds[0], 3'b000);
      if (k == 11) chk("tick_k11", leds[0], 3'b000);
      if (k == 12) chk("tick_k12", leds[0], 3'b001);
      $display("phaseC k=%0d rst=%0d led0=%b", k, (k == 8), leds[0]);
    end

    // Random reset pulses, sometimes held for several edges.
    for (int n = 0; n < 1500; n++) begin
      logic r;
      r = ($urandom_range(0, 99) < 4);
      step_edge(r);
      if (r && $urandom_range(0, 3) == 0) begin
        step_edge(1'b1);
        step_edge(1'b1);
      end
    end
    $display("random phase done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
